// File: rtl/ltsm_pkg.sv
// Shared LTSM definitions: state encoding and default timing constants.
// Used by the sequencer, its cycle timers and the LTSM top.
package ltsm_pkg;

  typedef enum logic [2:0] {
    RESET      = 3'd0,
    TRAIN      = 3'd1,
    ACTIVE     = 3'd2,
    TRAINERROR = 3'd3,
    FAIL       = 3'd4,
    L1_L2      = 3'd5
  } ltsm_state_t;

  // 4 ms dwell and 8 ms stage timeout at 100 MHz
  localparam int LTSM_DWELL_CYC_DEFAULT   = 400000;
  localparam int LTSM_TIMEOUT_CYC_DEFAULT = 800000;

  function automatic int ltsmCntWidth(input int maxVal);
    return (maxVal > 0) ? $clog2(maxVal + 1) : 1;
  endfunction

endpackage

// File: rtl/ltsm_cycle_timer.sv
// Loadable, clearable cycle counter that saturates at MAX_VAL.
// o_term flags the saturated (terminal) count.
module ltsm_cycle_timer
  import ltsm_pkg::*;
#(
  parameter int MAX_VAL = 15,
  localparam int W      = ltsmCntWidth(MAX_VAL)
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_inc,
  output logic         o_term
);

  localparam logic [W-1:0] MAX_CNT = W'(MAX_VAL);

  logic [W-1:0] r_count;

  // Clear has priority over load; a load value above the terminal count is clamped
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= (i_loadVal > MAX_CNT) ? MAX_CNT : i_loadVal;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_term = (r_count == MAX_CNT);

endmodule

// File: rtl/ltsm_seq_ctrl.sv
// Link-training sequencer: walks NUM_STAGES training stages with one-hot enables,
// dwell/timeout/retry handling. Optional power management: define LTSM_SEQ_PM_EN.
module ltsm_seq_ctrl
  import ltsm_pkg::*;
#(
  parameter int NUM_STAGES      = 4,
  parameter int RESET_DWELL_CYC = LTSM_DWELL_CYC_DEFAULT,
  parameter int TIMEOUT_CYC     = LTSM_TIMEOUT_CYC_DEFAULT,
  parameter int MAX_RETRY       = 3,
  parameter int RETRAIN_STAGE   = 2,
  localparam int SW             = $clog2(NUM_STAGES),
  localparam int RW             = $clog2(MAX_RETRY + 1)
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  start_lt_i,
  input  logic [NUM_STAGES-1:0] stage_done_i,
  input  logic [NUM_STAGES-1:0] stage_err_i,
  input  logic                  retrain_req_i,
`ifdef LTSM_SEQ_PM_EN
  input  logic                  pm_req_i,
  input  logic                  pm_exit_i,
  output logic                  pm_o,
`endif
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic [SW-1:0]         stage_sel_o,
  output logic [2:0]            state_o,
  output logic                  link_up_o,
  output logic                  train_error_o,
  output logic                  fail_o,
  output logic [RW-1:0]         retry_cnt_o
);

  localparam logic [SW-1:0] LAST_STAGE    = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0] RETRAIN_SEL   = SW'(RETRAIN_STAGE);
  localparam logic [RW-1:0] RETRY_LIMIT   = RW'(MAX_RETRY);
  localparam int            DWELL_MAX     = RESET_DWELL_CYC - 1;
  localparam int            TIMEOUT_MAX   = TIMEOUT_CYC - 1;

  ltsm_state_t   r_state;
  ltsm_state_t   w_nextState;
  logic [SW-1:0] r_stage;
  logic [SW-1:0] w_nextStage;
  logic [RW-1:0] r_retry;
  logic [RW-1:0] w_nextRetry;
  logic          w_advance;
  logic          w_dwellDone;
  logic          w_timeoutHit;
  logic          w_dwellClr;
  logic          w_toClr;

  // The dwell timer only counts while in RESET, so every RESET entry starts from zero
  assign w_dwellClr = (r_state != RESET);

  ltsm_cycle_timer #(
    .MAX_VAL (DWELL_MAX)
  ) u_dwellTimer (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .i_clear    (w_dwellClr),
    .i_load     (1'b0),
    .i_loadVal  ('0),
    .i_inc      (~w_dwellClr),
    .o_term     (w_dwellDone)
  );

  // Stage timeout restarts on every stage advance and whenever TRAIN is entered or left
  assign w_toClr = (r_state != TRAIN) || (w_nextState != TRAIN) || w_advance;

  ltsm_cycle_timer #(
    .MAX_VAL (TIMEOUT_MAX)
  ) u_timeoutTimer (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .i_clear    (w_toClr),
    .i_load     (1'b0),
    .i_loadVal  ('0),
    .i_inc      (~w_toClr),
    .o_term     (w_timeoutHit)
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= RESET;
      r_stage <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_nextState;
      r_stage <= w_nextStage;
      r_retry <= w_nextRetry;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextStage = r_stage;
    w_nextRetry = r_retry;
    w_advance   = 1'b0;
    if (!enable_i) begin
      // Disabling the block is an abort, not a failed attempt
      w_nextState = RESET;
      if (r_state != RESET) begin
        w_nextRetry = '0;
      end
    end else begin
      case (r_state)
        RESET: begin
          if (w_dwellDone && start_lt_i) begin
            w_nextState = TRAIN;
            w_nextStage = '0;
          end
        end
        TRAIN: begin
          if (stage_err_i[r_stage] || w_timeoutHit) begin
            w_nextState = TRAINERROR;
          end else if (stage_done_i[r_stage]) begin
            if (r_stage == LAST_STAGE) begin
              w_nextState = ACTIVE;
              w_nextRetry = '0;
            end else begin
              w_nextStage = r_stage + 1'b1;
              w_advance   = 1'b1;
            end
          end
        end
        ACTIVE: begin
          if (retrain_req_i) begin
            w_nextState = TRAIN;
            w_nextStage = RETRAIN_SEL;
          end
`ifdef LTSM_SEQ_PM_EN
          else if (pm_req_i) begin
            w_nextState = L1_L2;
          end
`endif
        end
        TRAINERROR: begin
          if (r_retry == RETRY_LIMIT) begin
            w_nextState = FAIL;
          end else begin
            w_nextRetry = r_retry + 1'b1;
            w_nextState = RESET;
          end
        end
        FAIL: begin
          w_nextState = FAIL;
        end
`ifdef LTSM_SEQ_PM_EN
        L1_L2: begin
          if (pm_exit_i) begin
            w_nextState = TRAIN;
            w_nextStage = RETRAIN_SEL;
          end
        end
`endif
        default: begin
          w_nextState = RESET;
        end
      endcase
    end
  end

  assign stage_en_o    = (r_state == TRAIN) ? (NUM_STAGES'(1) << r_stage) : '0;
  assign stage_sel_o   = r_stage;
  assign state_o       = r_state;
  assign link_up_o     = (r_state == ACTIVE);
  assign train_error_o = (r_state == TRAINERROR);
  assign fail_o        = (r_state == FAIL);
  assign retry_cnt_o   = r_retry;
`ifdef LTSM_SEQ_PM_EN
  assign pm_o          = (r_state == L1_L2);
`endif

endmodule

// File: tb/tb_ltsm_seq_ctrl.sv
// Self-checking bench for ltsm_seq_ctrl: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a behavioural sequencer model.
module tb_ltsm_seq_ctrl;

  localparam int N     = 4;
  localparam int DWELL = 8;
  localparam int TOUT  = 16;
  localparam int MAXR  = 2;
  localparam int RS    = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic [N-1:0] done;
  logic [N-1:0] err;
  logic         retrain;
  logic [N-1:0] stageEn;
  logic [1:0]   stageSel;
  logic [2:0]   stateO;
  logic         linkUp;
  logic         trainErr;
  logic         failO;
  logic [1:0]   retryCnt;
`ifdef LTSM_SEQ_PM_EN
  logic         pmReq;
  logic         pmExit;
  logic         pmO;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b1;

  // Model: state numbers follow the published encoding, counters are plain cycle counts
  int mState, mStage, mRetry, mDwell, mTo;

  ltsm_seq_ctrl #(
    .NUM_STAGES      (N),
    .RESET_DWELL_CYC (DWELL),
    .TIMEOUT_CYC     (TOUT),
    .MAX_RETRY       (MAXR),
    .RETRAIN_STAGE   (RS)
  ) dut (
    .clk_100MHz    (clk),
    .reset         (reset),
    .enable_i      (enable),
    .start_lt_i    (start),
    .stage_done_i  (done),
    .stage_err_i   (err),
    .retrain_req_i (retrain),
`ifdef LTSM_SEQ_PM_EN
    .pm_req_i      (pmReq),
    .pm_exit_i     (pmExit),
    .pm_o          (pmO),
`endif
    .stage_en_o    (stageEn),
    .stage_sel_o   (stageSel),
    .state_o       (stateO),
    .link_up_o     (linkUp),
    .train_error_o (trainErr),
    .fail_o        (failO),
    .retry_cnt_o   (retryCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic [N-1:0] d,
                               input logic [N-1:0] e, input logic rt);
    enable  = en;
    start   = st;
    done    = d;
    err     = e;
    retrain = rt;
  endtask

  task automatic modelReset();
    mState = 0; mStage = 0; mRetry = 0; mDwell = 0; mTo = 0;
  endtask

  // One clock of the sequencer rules, evaluated on the inputs present at the edge
  task automatic modelStep();
    int ns, nStage, nRetry;
    ns = mState; nStage = mStage; nRetry = mRetry;
    if (!enable) begin
      ns = 0;
      if (mState != 0) nRetry = 0;
    end else begin
      case (mState)
        0: if (mDwell >= DWELL - 1 && start) begin ns = 1; nStage = 0; end
        1: begin
          if (err[mStage] || mTo == TOUT - 1) ns = 3;
          else if (done[mStage]) begin
            if (mStage == N - 1) begin ns = 2; nRetry = 0; end
            else nStage = mStage + 1;
          end
        end
        2: begin
          if (retrain) begin ns = 1; nStage = RS; end
`ifdef LTSM_SEQ_PM_EN
          else if (pmReq) ns = 5;
`endif
        end
        3: if (mRetry == MAXR) ns = 4; else begin nRetry = mRetry + 1; ns = 0; end
        4: ns = 4;
`ifdef LTSM_SEQ_PM_EN
        5: if (pmExit) begin ns = 1; nStage = RS; end
`endif
        default: ns = 0;
      endcase
    end
    mDwell = (mState == 0 && ns == 0) ? ((mDwell + 1 > DWELL - 1) ? DWELL - 1 : mDwell + 1) : 0;
    mTo    = (mState == 1 && ns == 1 && nStage == mStage) ? mTo + 1 : 0;
    mState = ns; mStage = nStage; mRetry = nRetry;
  endtask

  always @(posedge clk) begin
    if (!reset) modelStep();
  end

  always @(posedge clk) begin
    #2;
    if (cmpEn) begin
      checkOutput("stage_en", int'(stageEn), (mState == 1) ? (1 << mStage) : 0);
      checkOutput("stage_sel", int'(stageSel), mStage);
      checkOutput("state", int'(stateO), mState);
      checkOutput("link_up", int'(linkUp), int'(mState == 2));
      checkOutput("train_error", int'(trainErr), int'(mState == 3));
      checkOutput("fail", int'(failO), int'(mState == 4));
      checkOutput("retry_cnt", int'(retryCnt), mRetry);
`ifdef LTSM_SEQ_PM_EN
      checkOutput("pm", int'(pmO), int'(mState == 5));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic doReset(input logic st);
    reset = 1'b1;
    modelReset();
    applyStimulus(1'b1, st, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic trainToActive();
    doReset(1'b1);
    repeat (DWELL) tick();
    for (int s = 0; s < N; s++) begin
      applyStimulus(1'b1, 1'b1, N'(1 << s), '0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int pulses;
    logic [N-1:0] rd;
    reset = 1'b1;
    modelReset();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
`ifdef LTSM_SEQ_PM_EN
    pmReq = 1'b0;
    pmExit = 1'b0;
`endif
    #1;
    checkOutput("reset_state", int'(stateO), 0);
    checkOutput("reset_en", int'(stageEn), 0);
    checkOutput("reset_link", int'(linkUp), 0);

    $display("[TB] scenario 1: first enable after dwell");
    doReset(1'b1);
    repeat (DWELL - 1) tick();
    checkOutput("t1_en_before", int'(stageEn), 0);
    tick();
    checkOutput("t1_en_first", int'(stageEn), 1);
    for (int s = 0; s < N; s++) begin
      applyStimulus(1'b1, 1'b1, N'(1 << s), '0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_link_up", int'(linkUp), 1);
    checkOutput("t1_state", int'(stateO), 2);

    $display("[TB] scenario 2: stage 1 timeout");
    doReset(1'b1);
    repeat (DWELL) tick();
    applyStimulus(1'b1, 1'b1, 4'b0001, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
    repeat (TOUT - 1) tick();
    checkOutput("t2_err_early", int'(trainErr), 0);
    tick();
    checkOutput("t2_err_17th", int'(trainErr), 1);
    tick();
    checkOutput("t2_state_reset", int'(stateO), 0);
    checkOutput("t2_retry", int'(retryCnt), 1);

    $display("[TB] scenario 5: retry clears in ACTIVE, then retrain");
    repeat (DWELL) tick();
    for (int s = 0; s < N; s++) begin
      applyStimulus(1'b1, 1'b0, N'(1 << s), '0, 1'b0);
      tick();
    end
    checkOutput("t5_retry_clear", int'(retryCnt), 0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("t5_en_retrain", int'(stageEn), 4);
    checkOutput("t5_link_down", int'(linkUp), 0);
    applyStimulus(1'b1, 1'b0, 4'b0100, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'b1000, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("t5_link_again", int'(linkUp), 1);

    $display("[TB] scenario 3: errors until retries run out");
    doReset(1'b1);
    applyStimulus(1'b1, 1'b1, '0, 4'b0001, 1'b0);
    pulses = 0;
    for (int i = 0; i < 200 && !failO; i++) begin
      tick();
      if (trainErr) pulses++;
    end
    checkOutput("t3_pulses", pulses, 3);
    checkOutput("t3_fail", int'(failO), 1);
    checkOutput("t3_state", int'(stateO), 4);
    repeat (5) tick();
    checkOutput("t3_sticky", int'(failO), 1);
    applyStimulus(1'b0, 1'b1, '0, 4'b0001, 1'b0);
    tick();
    checkOutput("t3_fail_clear", int'(failO), 0);
    checkOutput("t3_retry_clear", int'(retryCnt), 0);

    $display("[TB] scenario 4: simultaneous done/err and foreign done");
    doReset(1'b1);
    repeat (DWELL) tick();
    applyStimulus(1'b1, 1'b1, 4'b0001, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 4'b1000, '0, 1'b0);
    repeat (3) tick();
    checkOutput("t4_foreign_done", int'(stageEn), 2);
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0010, 1'b0);
    tick();
    checkOutput("t4_err_wins", int'(trainErr), 1);

    $display("[TB] scenario 6: async reset in stage 2");
    trainToActive();
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b1, 1'b1, '0, '0, 1'b0);
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("t6_en_async", int'(stageEn), 0);
    checkOutput("t6_state_async", int'(stateO), 0);
    tick();
    reset = 1'b0;
    repeat (DWELL - 1) tick();
    checkOutput("t6_en_wait", int'(stageEn), 0);
    tick();
    checkOutput("t6_en_retrain", int'(stageEn), 1);

`ifdef LTSM_SEQ_PM_EN
    $display("[TB] scenario 7: power management");
    trainToActive();
    pmReq = 1'b1;
    tick();
    pmReq = 1'b0;
    checkOutput("t7_pm", int'(pmO), 1);
    checkOutput("t7_link", int'(linkUp), 0);
    tick();
    pmExit = 1'b1;
    tick();
    pmExit = 1'b0;
    checkOutput("t7_exit_en", int'(stageEn), 4);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 0) doReset(1'($urandom_range(0, 1)));
      for (int b = 0; b < N; b++) rd[b] = ($urandom_range(0, 2) == 0);
      applyStimulus(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), rd,
                    ($urandom_range(0, 31) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0,
                    ($urandom_range(0, 15) == 0));
`ifdef LTSM_SEQ_PM_EN
      pmReq  = ($urandom_range(0, 7) == 0);
      pmExit = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
